// File: rtl/store_drain_if.sv
// Signal bundle for the store drain buffer: retired-store input, data-memory write port,
// load forwarding query and status flags.
interface store_drain_if;
    logic        store_wb;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_sh;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        ld_query;
    logic [31:0] ld_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
    logic        full;
    logic        empty;
    logic        misalign_err;
    logic        overflow_err;

    modport slave (
        input  store_wb, st_addr, st_data, st_sh, mem_ack, ld_query, ld_addr,
        output mem_we, mem_addr, mem_wdata, mem_be, fwd_hit, fwd_data, fwd_be,
               full, empty, misalign_err, overflow_err
    );

    modport master (
        output store_wb, st_addr, st_data, st_sh, mem_ack, ld_query, ld_addr,
        input  mem_we, mem_addr, mem_wdata, mem_be, fwd_hit, fwd_data, fwd_be,
               full, empty, misalign_err, overflow_err
    );
endinterface

// File: rtl/store_drain.sv
// Committed-store buffer: queues retired sw/sh stores, drains them one per cycle to data
// memory and forwards buffered data to younger loads.
module store_drain #(
    parameter int unsigned DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    store_drain_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } entry_t;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    entry_t        fifo_q [DEPTH];
    logic [PW-1:0] w_ptr_q, r_ptr_q;
    logic [CW-1:0] count_q;
    state_t        state_q, state_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic          misalign_q, overflow_q;

    entry_t        new_entry, head, next_head;
    logic          aligned, is_full, pop, push;
    logic          fwd_hit_c;
    logic [31:0]   fwd_data_c;
    logic [3:0]    fwd_be_c;
    logic [PW-1:0] idx;
    logic          unused_ld_lo;

    assign unused_ld_lo = ^bus.ld_addr[1:0];

    // Alignment check and lane placement of the retiring store
    always_comb begin
        aligned             = bus.st_sh ? ~bus.st_addr[0] : (bus.st_addr[1:0] == 2'b00);
        new_entry.word_addr = bus.st_addr[31:2];
        new_entry.wdata     = bus.st_data;
        new_entry.be        = 4'b1111;
        if (bus.st_sh) begin
            if (bus.st_addr[1]) begin
                new_entry.wdata = {bus.st_data[15:0], 16'h0000};
                new_entry.be    = 4'b1100;
            end else begin
                new_entry.wdata = {16'h0000, bus.st_data[15:0]};
                new_entry.be    = 4'b0011;
            end
        end
    end

    assign is_full   = (count_q == CW'(DEPTH));
    assign pop       = (state_q == WRITE) && bus.mem_ack;
    assign push      = bus.store_wb && aligned && (!is_full || pop);
    assign head      = fifo_q[r_ptr_q];
    assign next_head = fifo_q[r_ptr_q + PW'(1)];

    // FIFO storage, pointers, occupancy and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[w_ptr_q] <= new_entry;
                w_ptr_q         <= w_ptr_q + PW'(1);
            end
            if (pop) r_ptr_q <= r_ptr_q + PW'(1);
            count_q    <= count_q + CW'(push) - CW'(pop);
            misalign_q <= bus.store_wb && !aligned;
            overflow_q <= bus.store_wb && aligned && is_full && !pop;
        end
    end

    // Drain FSM: head entry is loaded into the write registers and held until acked
    always_comb begin
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {head.word_addr, 2'b00};
                    mem_wdata_d = head.wdata;
                    mem_be_d    = head.be;
                end
            end
            WRITE: begin
                if (bus.mem_ack) begin
                    if (count_q > CW'(1)) begin
                        mem_addr_d  = {next_head.word_addr, 2'b00};
                        mem_wdata_d = next_head.wdata;
                        mem_be_d    = next_head.be;
                    end else begin
                        state_d  = IDLE;
                        mem_we_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // Forwarding scans oldest to youngest so the youngest match wins
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_be_c   = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = r_ptr_q + PW'(i);
            if (bus.ld_query && (CW'(i) < count_q) &&
                (fifo_q[idx].word_addr == bus.ld_addr[31:2])) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = fifo_q[idx].wdata;
                fwd_be_c   = fifo_q[idx].be;
            end
        end
    end

    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_be       = mem_be_q;
    assign bus.fwd_hit      = fwd_hit_c;
    assign bus.fwd_data     = fwd_data_c;
    assign bus.fwd_be       = fwd_be_c;
    assign bus.full         = is_full;
    assign bus.empty        = (count_q == '0);
    assign bus.misalign_err = misalign_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_store_drain.sv
// Directed self-checking bench for store_drain with DEPTH=4.
module tb_store_drain;
    logic        clk = 1'b0;
    logic        reset;
    int          passed = 0;
    int          total  = 0;
    int          ovf_cnt = 0;
    logic [63:0] got_q[$];

    store_drain_if bus();
    store_drain #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Records every accepted memory write and every overflow pulse
    always @(posedge clk) begin
        if (reset && bus.mem_we && bus.mem_ack) got_q.push_back({bus.mem_addr, bus.mem_wdata});
        if (bus.overflow_err) ovf_cnt <= ovf_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic sh, input logic [31:0] a, input logic [31:0] d);
        bus.store_wb = 1'b1;
        bus.st_sh    = sh;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.store_wb = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bus.empty !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.empty), 32'd1);
    endtask

    initial begin
        int sent, fullpop, cyc, ovf_base;
        reset        = 1'b0;
        bus.store_wb = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.st_sh    = 1'b0;
        bus.mem_ack  = 1'b0;
        bus.ld_query = 1'b0;
        bus.ld_addr  = '0;

        // Reset state
        #12;
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        chk("rst_overflow", 32'(bus.overflow_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single sw, ack tied high: two-cycle latency then drain
        bus.mem_ack = 1'b1;
        push(1'b0, 32'h100, 32'hDEADBEEF);
        chk("sw_push_we", 32'(bus.mem_we), 32'd0);
        chk("sw_push_empty", 32'(bus.empty), 32'd0);
        tick();
        chk("sw_we", 32'(bus.mem_we), 32'd1);
        chk("sw_addr", bus.mem_addr, 32'h100);
        chk("sw_be", 32'(bus.mem_be), 32'hF);
        chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        chk("sw_done_empty", 32'(bus.empty), 32'd1);
        chk("sw_done_we", 32'(bus.mem_we), 32'd0);

        // Halfword lanes and misalignment
        push(1'b1, 32'h202, 32'h1234ABCD);
        tick();
        chk("sh_hi_addr", bus.mem_addr, 32'h200);
        chk("sh_hi_be", 32'(bus.mem_be), 32'hC);
        chk("sh_hi_wdata", bus.mem_wdata, 32'hABCD0000);
        tick();
        push(1'b1, 32'h200, 32'h1234ABCD);
        tick();
        chk("sh_lo_be", 32'(bus.mem_be), 32'h3);
        chk("sh_lo_wdata", bus.mem_wdata, 32'h0000ABCD);
        tick();
        chk("sh_lo_done_we", 32'(bus.mem_we), 32'd0);
        push(1'b1, 32'h201, 32'h1234ABCD);
        chk("sh_mis_pulse", 32'(bus.misalign_err), 32'd1);
        chk("sh_mis_empty", 32'(bus.empty), 32'd1);
        tick();
        chk("sh_mis_clear", 32'(bus.misalign_err), 32'd0);
        chk("sh_mis_no_we", 32'(bus.mem_we), 32'd0);
        push(1'b0, 32'h102, 32'h55555555);
        chk("sw_mis_pulse", 32'(bus.misalign_err), 32'd1);
        tick();
        chk("sw_mis_empty", 32'(bus.empty), 32'd1);

        // Fill with ack low, overflow, then back-to-back drain
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b0, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_we", 32'(bus.mem_we), 32'd1);
        chk("fill_addr", bus.mem_addr, 32'h10);
        push(1'b0, 32'h20, 32'hEE);
        chk("ovf_pulse", 32'(bus.overflow_err), 32'd1);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_addr_stable", bus.mem_addr, 32'h10);
        tick();
        chk("ovf_clear", 32'(bus.overflow_err), 32'd0);
        chk("hold_addr", bus.mem_addr, 32'h10);
        chk("hold_wdata", bus.mem_wdata, 32'hA0);
        chk("hold_we", 32'(bus.mem_we), 32'd1);
        bus.mem_ack = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("b2b_we", 32'(bus.mem_we), 32'd1);
            chk("b2b_addr", bus.mem_addr, 32'h10 + 32'(4 * i));
            chk("b2b_wdata", bus.mem_wdata, 32'hA0 + 32'(i));
            if (i == 1) chk("b2b_not_full", 32'(bus.full), 32'd0);
        end
        tick();
        chk("b2b_done_we", 32'(bus.mem_we), 32'd0);
        chk("b2b_done_empty", 32'(bus.empty), 32'd1);

        // Forwarding: youngest match, miss, same-cycle push invisible
        bus.mem_ack = 1'b0;
        push(1'b0, 32'h40, 32'h11111111);
        push(1'b0, 32'h40, 32'h22222222);
        bus.ld_query = 1'b1;
        bus.ld_addr  = 32'h42;
        #1;
        chk("fwd_hit", 32'(bus.fwd_hit), 32'd1);
        chk("fwd_data", bus.fwd_data, 32'h22222222);
        chk("fwd_be", 32'(bus.fwd_be), 32'hF);
        bus.ld_addr = 32'h44;
        #1;
        chk("fwd_miss_hit", 32'(bus.fwd_hit), 32'd0);
        chk("fwd_miss_data", bus.fwd_data, 32'h0);
        chk("fwd_miss_be", 32'(bus.fwd_be), 32'h0);
        bus.ld_addr  = 32'h80;
        bus.store_wb = 1'b1;
        bus.st_sh    = 1'b0;
        bus.st_addr  = 32'h80;
        bus.st_data  = 32'h33333333;
        #1;
        chk("fwd_same_cycle", 32'(bus.fwd_hit), 32'd0);
        tick();
        bus.store_wb = 1'b0;
        chk("fwd_next_hit", 32'(bus.fwd_hit), 32'd1);
        chk("fwd_next_data", bus.fwd_data, 32'h33333333);
        push(1'b1, 32'h42, 32'h00005555);
        bus.ld_addr = 32'h40;
        #1;
        chk("fwd_sh_data", bus.fwd_data, 32'h55550000);
        chk("fwd_sh_be", 32'(bus.fwd_be), 32'hC);
        bus.ld_query = 1'b0;
        #1;
        chk("fwd_noquery", 32'(bus.fwd_hit), 32'd0);
        bus.mem_ack = 1'b1;
        drain("fwd_drain_empty");

        // Ten stores with toggling ack, including full-with-pop pushes
        tick();
        got_q.delete();
        ovf_base = ovf_cnt;
        sent = 0;
        fullpop = 0;
        cyc = 0;
        while (sent < 10 && cyc < 100) begin
            bus.mem_ack = cyc[0];
            if (!bus.full || (bus.mem_ack && bus.mem_we)) begin
                if (bus.full) fullpop++;
                bus.store_wb = 1'b1;
                bus.st_sh    = 1'b0;
                bus.st_addr  = 32'h300 + 32'(4 * sent);
                bus.st_data  = 32'hC0DE0000 + 32'(sent);
                sent++;
            end else begin
                bus.store_wb = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.store_wb = 1'b0;
        bus.mem_ack  = 1'b1;
        drain("stream_empty");
        chk("stream_sent", 32'(sent), 32'd10);
        chk("stream_fullpop_seen", 32'(fullpop > 0), 32'd1);
        chk("stream_no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);
        chk("stream_count", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) begin
                chk("stream_addr", got_q[i][63:32], 32'h300 + 32'(4 * i));
                chk("stream_data", got_q[i][31:0], 32'hC0DE0000 + 32'(i));
            end
        end

        // Reset in the middle of a write
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) push(1'b0, 32'h500 + 32'(4 * i), 32'hB0 + 32'(i));
        chk("mid_we", 32'(bus.mem_we), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_full", 32'(bus.full), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_we", 32'(bus.mem_we), 32'd0);
        end
        chk("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
